dram_wr_sched: RTL

DRAM_WR_SCHED -- requirements
Module: dram_wr_sched

---
 rtl/dram_wr_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dram_wr_sched.sv
// dram_wr_sched: drains 256b words from a write FIFO into a DRAM application
// port as single BL8 write commands. Addresses advance linearly from the
// armed base address and either wrap (ring buffer) or stop at the end address.
module dram_wr_sched #(
  parameter int ADDR_WIDTH = 27,
  parameter int ADDR_INC   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  wrap_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  input  logic [255:0]          fifo_dout,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  input  logic                  app_rdy,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [255:0]          app_wdf_data,
  input  logic                  app_wdf_rdy,
  output logic                  busy,
  output logic                  mem_full,
  output logic                  wrapped,
  output logic [31:0]           words_written
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, HALT} state_t;

  state_t                state_reg;
  logic                  enable_prev_reg;
  logic                  armed_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] end_reg;
  logic                  wrap_reg;
  logic [255:0]          data_reg;
  logic                  app_en_reg;
  logic                  wren_reg;
  logic                  cmd_done_reg;
  logic                  data_done_reg;
  logic                  mem_full_reg;
  logic                  wrapped_reg;
  logic [31:0]           words_reg;

  logic                  arm_evt;
  logic                  cmd_acc;
  logic                  data_acc;
  logic                  complete;
  logic [ADDR_WIDTH:0]   next_addr_wide;
  logic                  at_boundary;
  logic                  halt_now;
  logic                  idle_read;
  logic                  chain_read;

  // Arm on an enable rising edge seen while idle.
  assign arm_evt  = (state_reg == IDLE) && enable && !enable_prev_reg;
  assign cmd_acc  = app_en_reg && app_rdy;
  assign data_acc = wren_reg && app_wdf_rdy;

  // A word completes on the cycle the later of command/data is accepted.
  assign complete = (state_reg == ISSUE) && (cmd_done_reg || cmd_acc) &&
                    (data_done_reg || data_acc);

  // One extra bit so the boundary compare cannot be fooled by overflow.
  assign next_addr_wide = {1'b0, addr_reg} + (ADDR_WIDTH + 1)'(ADDR_INC);
  assign at_boundary    = next_addr_wide >= {1'b0, end_reg};
  assign halt_now       = at_boundary && !wrap_reg;

  // Reads happen either from IDLE or chained onto a completing word so that
  // back-to-back words need no idle cycle in between.
  assign idle_read  = (state_reg == IDLE) && enable && !arm_evt && armed_reg &&
                      !mem_full_reg && !fifo_empty;
  assign chain_read = complete && enable && !fifo_empty && !halt_now;
  assign fifo_rden  = idle_read || chain_read;

  assign app_en        = app_en_reg;
  assign app_cmd       = 3'b000;
  assign app_addr      = addr_reg;
  assign app_wdf_wren  = wren_reg;
  assign app_wdf_end   = wren_reg;
  assign app_wdf_data  = data_reg;
  assign busy          = (state_reg != IDLE);
  assign mem_full      = mem_full_reg;
  assign wrapped       = wrapped_reg;
  assign words_written = words_reg;

  // Main scheduler FSM with all status and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      enable_prev_reg <= 1'b0;
      armed_reg       <= 1'b0;
      addr_reg        <= '0;
      base_reg        <= '0;
      end_reg         <= '0;
      wrap_reg        <= 1'b0;
      data_reg        <= '0;
      app_en_reg      <= 1'b0;
      wren_reg        <= 1'b0;
      cmd_done_reg    <= 1'b0;
      data_done_reg   <= 1'b0;
      mem_full_reg    <= 1'b0;
      wrapped_reg     <= 1'b0;
      words_reg       <= '0;
    end else begin
      enable_prev_reg <= enable;
      case (state_reg)
        IDLE: begin
          if (arm_evt) begin
            addr_reg    <= base_addr;
            base_reg    <= base_addr;
            end_reg     <= end_addr;
            wrap_reg    <= wrap_en;
            words_reg   <= '0;
            wrapped_reg <= 1'b0;
            armed_reg   <= 1'b1;
            if (base_addr >= end_addr) begin
              mem_full_reg <= 1'b1;
              state_reg    <= HALT;
            end else begin
              mem_full_reg <= 1'b0;
            end
          end else if (idle_read) begin
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          data_reg  <= fifo_dout;
          state_reg <= LOAD;
        end
        LOAD: begin
          app_en_reg    <= 1'b1;
          wren_reg      <= 1'b1;
          cmd_done_reg  <= 1'b0;
          data_done_reg <= 1'b0;
          state_reg     <= ISSUE;
        end
        ISSUE: begin
          if (complete) begin
            app_en_reg <= 1'b0;
            wren_reg   <= 1'b0;
            words_reg  <= words_reg + 32'd1;
            if (at_boundary && wrap_reg) begin
              addr_reg    <= base_reg;
              wrapped_reg <= 1'b1;
            end else begin
              addr_reg <= next_addr_wide[ADDR_WIDTH-1:0];
            end
            if (halt_now) begin
              mem_full_reg <= 1'b1;
              state_reg    <= HALT;
            end else if (chain_read) begin
              state_reg <= FETCH;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            if (cmd_acc) begin
              app_en_reg   <= 1'b0;
              cmd_done_reg <= 1'b1;
            end
            if (data_acc) begin
              wren_reg      <= 1'b0;
              data_done_reg <= 1'b1;
            end
          end
        end
        HALT: begin
          if (!enable) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
